// File: rtl/avg_pool_sequencer.sv
// Sequencer for 2x2 average pooling: walks image windows, drives the averaging unit, writes pooled buffer.
// Optional watchdog in WAIT enabled by defining POOL_TIMEOUT_EN.
module avg_pool_sequencer #(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int PIX_W       = 8,
    parameter int ADDR_W      = 10,
    parameter int OUT_ADDR_W  = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W-1:0]     pix_addr0,
    output logic [ADDR_W-1:0]     pix_addr1,
    output logic [ADDR_W-1:0]     pix_addr2,
    output logic [ADDR_W-1:0]     pix_addr3,
    output logic                  avg_start,
    input  logic                  avg_done,
    input  logic [PIX_W-1:0]      avg_result,
    output logic                  out_we,
    output logic [OUT_ADDR_W-1:0] out_addr,
    output logic [PIX_W-1:0]      out_data
);

    localparam int COLS = IMG_W / 2;
    localparam int ROWS = IMG_H / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0]     base, base_n;
    logic [OUT_ADDR_W-1:0] col, col_n;
    logic [OUT_ADDR_W-1:0] row, row_n;
    logic [OUT_ADDR_W-1:0] idx, idx_n;
    logic                  last_win;

    logic [ADDR_W-1:0]     pix_addr0_n, pix_addr1_n, pix_addr2_n, pix_addr3_n;
    logic [OUT_ADDR_W-1:0] out_addr_n;
    logic [PIX_W-1:0]      out_data_n;

    assign last_win = (row == OUT_ADDR_W'(ROWS - 1)) && (col == OUT_ADDR_W'(COLS - 1));

`ifdef POOL_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] wait_cnt;
    logic             err_n;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign err = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        base_n      = base;
        col_n       = col;
        row_n       = row;
        idx_n       = idx;
        out_addr_n  = out_addr;
        out_data_n  = out_data;
        pix_addr0_n = pix_addr0;
        pix_addr1_n = pix_addr1;
        pix_addr2_n = pix_addr2;
        pix_addr3_n = pix_addr3;
`ifdef POOL_TIMEOUT_EN
        err_n       = err;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ISSUE;
                    base_n  = '0;
                    col_n   = '0;
                    row_n   = '0;
                    idx_n   = '0;
                end
            end
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                if (avg_done) begin
                    state_n    = S_WRITE;
                    out_data_n = avg_result;
                    out_addr_n = idx;
                end
`ifdef POOL_TIMEOUT_EN
                else if (wait_cnt == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                end
`endif
            end
            S_WRITE: begin
                if (last_win) begin
                    state_n = S_FINISH;
                end else begin
                    state_n = S_ISSUE;
                    idx_n   = idx + OUT_ADDR_W'(1);
                    // End of a window row: skip the odd image row the windows just covered.
                    if (col == OUT_ADDR_W'(COLS - 1)) begin
                        col_n  = '0;
                        row_n  = row + OUT_ADDR_W'(1);
                        base_n = base + ADDR_W'(IMG_W + 2);
                    end else begin
                        col_n  = col + OUT_ADDR_W'(1);
                        base_n = base + ADDR_W'(2);
                    end
                end
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase

        // Window addresses are latched on entry to ISSUE and held through WRITE.
        if (state_n == S_ISSUE) begin
            pix_addr0_n = base_n;
            pix_addr1_n = base_n + ADDR_W'(1);
            pix_addr2_n = base_n + ADDR_W'(IMG_W);
            pix_addr3_n = base_n + ADDR_W'(IMG_W + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            base      <= '0;
            col       <= '0;
            row       <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            avg_start <= 1'b0;
            out_we    <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            pix_addr0 <= '0;
            pix_addr1 <= '0;
            pix_addr2 <= '0;
            pix_addr3 <= '0;
        end else begin
            state     <= state_n;
            base      <= base_n;
            col       <= col_n;
            row       <= row_n;
            idx       <= idx_n;
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_FINISH);
            avg_start <= (state_n == S_ISSUE);
            out_we    <= (state_n == S_WRITE);
            out_addr  <= out_addr_n;
            out_data  <= out_data_n;
            pix_addr0 <= pix_addr0_n;
            pix_addr1 <= pix_addr1_n;
            pix_addr2 <= pix_addr2_n;
            pix_addr3 <= pix_addr3_n;
        end
    end

`ifdef POOL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= err_n;
            if (state_n == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT && !avg_done) begin
                wait_cnt <= wait_cnt + TMR_W'(1);
            end
        end
    end
`endif

endmodule
